oric_tap_recorder: RTL and testbench
====================================

Name: oric_tap_recorder

Overview:
- Record-side counterpart of the TAP player.
- Measures the Oric cassette output waveform (K7_TAPEOUT), decodes Oric fast-format bit cells into framed bytes, and emits each byte with a sequential address over a toggle req/ack handshake.
- The top-level arbiter writes those bytes into SDRAM port2 using that handshake, producing a .TAP image.
- Runs in the clk_24 domain and measures time in ce ticks (1 MHz, same strobe as the player).

Parameters:
- ADDR_W, 24, width of byte_addr / byte_count.
- SHORT_MAX, 312, longest period in ce ticks decoded as bit 1 (nominal 1 = 208 us, 0 = 416 us).
- GLITCH_MIN, 100, periods shorter than this are ignored as noise.
- GAP_MAX, 1000, a period or quiet time longer than this is a gap.

Ports:
- clk  in  1  system clock (clk_24)
- reset  in  1  synchronous, active-high
- ce  in  1  1 MHz timing strobe, one clk wide
- record  in  1  record enable (OSD toggle)
- motor_on  in  1  cassette remote (K7_REMOTE)
- tape_in  in  1  Oric cassette output level
- byte_req  out  1  toggles once per byte offered
- byte_ack  in  1  byte consumed when byte_ack == byte_req
- byte_addr  out  ADDR_W  address of offered byte
- byte_out  out  8  offered byte
- byte_count  out  ADDR_W  bytes accepted since reset
- recording  out  1  high when not in IDLE
- overflow  out  1  sticky: a byte was dropped
- full  out  1  address space exhausted

Behaviour:
- Reset values: byte_req=0, byte_addr=0, byte_out=0, byte_count=0, recording=0, overflow=0, full=0, state=IDLE, period counter=0.
- Input conditioning:
  - tape_in passes a 2-flop synchroniser; a rising edge of the synchronised signal marks the end of a period.
  - The period counter increments on ce, saturates at 4095, and clears on each accepted edge.
- Period classification, evaluated on the rising-edge cycle:
  - count < GLITCH_MIN: ignore; counter NOT cleared.
  - count <= SHORT_MAX: bit 1.
  - count <= GAP_MAX: bit 0.
  - otherwise: gap.
- Gap timeout: counter exceeding GAP_MAX with no edge is also a gap; act on it at the first such cycle.
- FSM:
  - IDLE: go to HUNT when record & motor_on.
  - HUNT: on bit 0 (start bit), clear the shift register and parity accumulator, set bit index 0, go to DATA. Bit 1 and gap stay in HUNT.
  - DATA: shift in LSB first (shift right, new bit at [7]) and XOR into the parity accumulator. After 8 bits go to PARITY. A gap returns to HUNT and discards the partial byte.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: bit 1 completes the byte → EMIT. Bit 0 is a framing error: drop the byte, go to HUNT. A gap also drops the byte and goes to HUNT.
  - EMIT (one cycle):
    - If byte_req != byte_ack or full=1: set overflow, drop the byte.
    - Else: byte_out <= byte, byte_req <= ~byte_req.
    - Go to HUNT. Remaining stop bits are absorbed there as bit 1.
- Handshake:
  - A byte is outstanding while byte_req != byte_ack.
  - byte_out and byte_addr are stable while outstanding.
  - On the first cycle byte_ack == byte_req after an offer: byte_addr and byte_count increment by 1.
  - When byte_addr = 2^ADDR_W-1 is acknowledged: set full; byte_addr holds (no wrap).
- Stop conditions:
  - record=0 or motor_on=0 in any state → IDLE next cycle; a partial byte is discarded.
  - An already-offered byte stays offered until acked, and its ack still increments.
  - byte_addr and byte_count are kept across stops, so recording appends.
- Reset mid-handshake: byte_req returns to 0. The top level resets byte_ack together with this block (both on tap download start), so no phantom ack occurs.
- Simultaneous events: ack increment and a new EMIT in the same cycle → the ack is processed first, and EMIT sees the handshake as free.

Optional Feature:
- Macro: ORIC_TAP_REC_PARITY_CHECK_EN.
- Defined:
  - In STOP, a byte whose data bits plus parity bit contain an even number of ones is dropped.
  - Sticky output parity_err (1 bit, reset 0) is added and set on each such drop.
- Undefined: the parity bit is consumed and ignored, and the port parity_err does not exist.

Test Plan:
- Record=1, motor=1; drive 0x16 framed as start 0 (416 us), bits LSB first, odd parity, 3 stop 1s (208 us); hold byte_ack to follow byte_req after 5 clk → byte_out=0x16, byte_addr=0 on the toggle, then byte_addr=1, byte_count=1.
- Four bytes 0x16,0x16,0x24,0x55 back-to-back → four toggles; the addresses offered are 0,1,2,3; byte_count=4; overflow=0.
- Never ack; send two bytes → first byte 0x16 held stable, second dropped, overflow=1, byte_count=0 until ack.
- 50 us glitch pulses inside a data bit, plus a 1500 us gap after 4 data bits → glitches ignored; the partial byte is discarded with no toggle; the next full byte decodes correctly.
- Deassert motor_on mid-byte, then reassert and send 0xAA → no toggle for the partial byte; 0xAA emitted at the next address.
- With ORIC_TAP_REC_PARITY_CHECK_EN: 0x01 sent with parity bit 1 → dropped, parity_err=1, no toggle.

Source files
------------

// File: rtl/oric_tap_recorder.sv
// rtl/oric_tap_recorder.sv - Oric fast-format cassette recorder producing framed TAP bytes
//
// Measures the Oric cassette output between rising edges in ce ticks,
// decodes fast-format bit cells (start 0, 8 data bits LSB first, parity,
// stop 1s) and offers each decoded byte with a sequential address over a
// toggle req/ack handshake.
//
// Build macro: ORIC_TAP_REC_PARITY_CHECK_EN adds odd-parity checking and the
// sticky parity_err output; without it the parity bit is consumed unchecked.
//
// Ports:
//   clk         system clock (clk_24)
//   reset       synchronous, active-high
//   ce          1 MHz timing strobe, one clk wide
//   record      record enable
//   motor_on    cassette remote
//   tape_in     cassette output level (asynchronous)
//   byte_req    toggles once per byte offered
//   byte_ack    byte consumed when byte_ack == byte_req
//   byte_addr   address of the offered byte
//   byte_out    offered byte
//   byte_count  bytes accepted since reset
//   recording   high when not idle
//   overflow    sticky, a decoded byte was dropped
//   full        address space exhausted
//   parity_err  sticky, a byte failed the parity check (macro builds only)

module oric_tap_recorder #(
    parameter int ADDR_W     = 24,
    parameter int SHORT_MAX  = 312,
    parameter int GLITCH_MIN = 100,
    parameter int GAP_MAX    = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              record,
    input  logic              motor_on,
    input  logic              tape_in,
    output logic              byte_req,
    input  logic              byte_ack,
    output logic [ADDR_W-1:0] byte_addr,
    output logic [7:0]        byte_out,
    output logic [ADDR_W-1:0] byte_count,
    output logic              recording,
    output logic              overflow,
    output logic              full
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
    ,
    output logic              parity_err
`endif
);

    localparam logic [11:0]       GLITCH_L = 12'(GLITCH_MIN);
    localparam logic [11:0]       SHORT_L  = 12'(SHORT_MAX);
    localparam logic [11:0]       GAP_L    = 12'(GAP_MAX);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_EMIT
    } state_t;

    state_t      state;
    logic        tape_s1, tape_s2, tape_d;
    logic [11:0] period_cnt;
    logic        timeout_done;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic        offer_open;
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
    logic        par_acc;
    logic        par_bit;
`endif

    logic edge_ok, timeout, is_one, is_zero, is_gap;
    logic ack_now, full_next, run;

    // Rising edges shorter than GLITCH_MIN are not edges at all: they leave
    // the period counter running so the real period is still measured whole.
    assign edge_ok = tape_s2 && !tape_d && (period_cnt >= GLITCH_L);
    // Quiet-line gap fires once per quiet stretch, on the first cycle past GAP_MAX.
    assign timeout = !edge_ok && !timeout_done && (period_cnt > GAP_L);
    assign is_one  = edge_ok && (period_cnt <= SHORT_L);
    assign is_zero = edge_ok && (period_cnt > SHORT_L) && (period_cnt <= GAP_L);
    assign is_gap  = (edge_ok && (period_cnt > GAP_L)) || timeout;

    // An acknowledge is retired before a same-cycle EMIT looks at the handshake.
    assign ack_now   = offer_open && (byte_req == byte_ack);
    assign full_next = full || (ack_now && (byte_addr == ADDR_MAX));
    assign run       = record && motor_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            tape_s1      <= 1'b0;
            tape_s2      <= 1'b0;
            tape_d       <= 1'b0;
            period_cnt   <= 12'd0;
            timeout_done <= 1'b0;
        end else begin
            tape_s1 <= tape_in;
            tape_s2 <= tape_s1;
            tape_d  <= tape_s2;
            if (edge_ok) begin
                period_cnt   <= 12'd0;
                timeout_done <= 1'b0;
            end else begin
                if (ce && (period_cnt != 12'hFFF))
                    period_cnt <= period_cnt + 12'd1;
                if (timeout)
                    timeout_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            byte_req   <= 1'b0;
            byte_addr  <= '0;
            byte_out   <= 8'd0;
            byte_count <= '0;
            recording  <= 1'b0;
            overflow   <= 1'b0;
            full       <= 1'b0;
            shreg      <= 8'd0;
            bit_idx    <= 3'd0;
            offer_open <= 1'b0;
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
            par_acc    <= 1'b0;
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            // The handshake keeps running while stopped so an offered byte
            // is still accounted for when its ack arrives.
            if (ack_now) begin
                offer_open <= 1'b0;
                byte_count <= byte_count + 1'b1;
                if (byte_addr == ADDR_MAX)
                    full <= 1'b1;
                else
                    byte_addr <= byte_addr + 1'b1;
            end

            if (!run) begin
                state     <= S_IDLE;
                recording <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state     <= S_HUNT;
                        recording <= 1'b1;
                    end
                    S_HUNT: begin
                        if (is_zero) begin
                            shreg   <= 8'd0;
                            bit_idx <= 3'd0;
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
                            par_acc <= 1'b0;
`endif
                            state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (is_gap) begin
                            state <= S_HUNT;
                        end else if (is_one || is_zero) begin
                            shreg   <= {is_one, shreg[7:1]};
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
                            par_acc <= par_acc ^ is_one;
`endif
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7)
                                state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        if (is_gap) begin
                            state <= S_HUNT;
                        end else if (is_one || is_zero) begin
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
                            par_bit <= is_one;
`endif
                            state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (is_gap || is_zero) begin
                            state <= S_HUNT;
                        end else if (is_one) begin
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
                            // Odd parity: data plus parity must hold an odd count of ones.
                            if (!(par_acc ^ par_bit)) begin
                                parity_err <= 1'b1;
                                state      <= S_HUNT;
                            end else begin
                                state <= S_EMIT;
                            end
`else
                            state <= S_EMIT;
`endif
                        end
                    end
                    S_EMIT: begin
                        if ((byte_req != byte_ack) || full_next) begin
                            overflow <= 1'b1;
                        end else begin
                            byte_out   <= shreg;
                            byte_req   <= ~byte_req;
                            offer_open <= 1'b1;
                        end
                        state <= S_HUNT;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oric_tap_recorder.sv
// tb/tb_oric_tap_recorder.sv - self-checking bench for oric_tap_recorder

module tb_oric_tap_recorder;

    localparam int AW   = 3;
    localparam int AMAX = (1 << AW) - 1;

    logic          clk;
    logic          reset;
    logic          ce;
    logic          record;
    logic          motor_on;
    logic          tape_in;
    logic          byte_req;
    logic          byte_ack;
    logic [AW-1:0] byte_addr;
    logic [7:0]    byte_out;
    logic [AW-1:0] byte_count;
    logic          recording;
    logic          overflow;
    logic          full;
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
    logic          parity_err;
`endif

    oric_tap_recorder #(
        .ADDR_W    (AW),
        .SHORT_MAX (312),
        .GLITCH_MIN(100),
        .GAP_MAX   (1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .record    (record),
        .motor_on  (motor_on),
        .tape_in   (tape_in),
        .byte_req  (byte_req),
        .byte_ack  (byte_ack),
        .byte_addr (byte_addr),
        .byte_out  (byte_out),
        .byte_count(byte_count),
        .recording (recording),
        .overflow  (overflow),
        .full      (full)
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
        ,
        .parity_err(parity_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit ack_en = 0;

    int mon_q[$];
    int mon_base = 0;
    int exp_q[$];
    int model_addr = 0;
    bit model_full = 0;
    bit model_ovf  = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run did not complete within the time limit");
        $fatal(1);
    end

    // Records every offer (address, data) at the toggle of byte_req.
    initial begin
        logic last_req;
        last_req = 0;
        forever begin
            @(negedge clk);
            if (!reset && (byte_req !== last_req))
                mon_q.push_back(int'(byte_addr) * 256 + int'(byte_out));
            last_req = byte_req;
        end
    end

    // Consumer: follows byte_req five clocks after it changes.
    initial begin
        byte_ack = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                byte_ack = 0;
            end else if (ack_en && (byte_ack !== byte_req)) begin
                repeat (5) @(negedge clk);
                if (!reset) byte_ack = byte_req;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_us(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit cell: high half then low half, ending on the rising edge.
    task automatic send_bit(input logic b, input bit glitch);
        int len;
        len = (b ? 208 : 416) + int'($urandom_range(0, 30)) - 15;
        if (glitch) begin
            wait_us(30);
            tape_in = 0;
            wait_us(20);
            tape_in = 1;
            wait_us(len / 2 - 50);
        end else begin
            wait_us(len / 2);
        end
        tape_in = 0;
        wait_us(len - len / 2);
        tape_in = 1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit bad_par,
                              input int nstop, input bit glitch);
        logic p;
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        for (int i = 0; i < nbits; i++) send_bit(d[i], glitch);
        if (nbits == 8) begin
            p = ~^d;
            if (bad_par) p = ~p;
            send_bit(p, 0);
            for (int i = 0; i < nstop; i++) send_bit(1'b1, 0);
        end
    endtask

    // A complete, well-framed byte reaching the output stage with the handshake free.
    task automatic model_byte(input logic [7:0] d);
        if (model_full) begin
            model_ovf = 1;
        end else begin
            exp_q.push_back(model_addr * 256 + int'(d));
            if (model_addr == AMAX) model_full = 1;
            else model_addr++;
        end
    endtask

    task automatic check_offers(input string tag);
        check({tag, "_n"}, mon_q.size() - mon_base, exp_q.size());
        for (int i = 0; i < exp_q.size() && (mon_base + i) < mon_q.size(); i++)
            check({tag, "_offer"}, mon_q[mon_base + i], exp_q[i]);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        mon_base   = mon_q.size();
        exp_q.delete();
        model_addr = 0;
        model_full = 0;
        model_ovf  = 0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] t2 [4];
        t2[0] = 8'h16; t2[1] = 8'h16; t2[2] = 8'h24; t2[3] = 8'h55;
        reset = 1; ce = 1; record = 0; motor_on = 0; tape_in = 1;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_req", byte_req, 0);
        check("rst_addr", byte_addr, 0);
        check("rst_out", byte_out, 0);
        check("rst_count", byte_count, 0);
        check("rst_rec", recording, 0);
        check("rst_ovf", overflow, 0);
        check("rst_full", full, 0);
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
        check("rst_perr", parity_err, 0);
`endif
        wait_us(20);
        check("idle_rec", recording, 0);

        // Single byte with following ack
        record = 1; motor_on = 1; ack_en = 1;
        wait_us(3);
        check("t1_rec", recording, 1);
        send_frame(8'h16, 8, 0, 3, 0);
        model_byte(8'h16);
        wait_us(20);
        check_offers("t1");
        check("t1_addr", byte_addr, model_addr);
        check("t1_count", byte_count, exp_q.size());
        check("t1_ovf", overflow, 0);

        // Four bytes back to back
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_frame(t2[i], 8, 0, 3, 0);
            model_byte(t2[i]);
        end
        wait_us(20);
        check_offers("t2");
        check("t2_count", byte_count, 4);
        check("t2_req", byte_req, exp_q.size() % 2);
        check("t2_ovf", overflow, 0);

        // No ack: second byte dropped while the first stays offered
        do_reset();
        ack_en = 0;
        send_frame(8'h16, 8, 0, 3, 0);
        send_frame(8'h16, 8, 0, 3, 0);
        exp_q.push_back(8'h16);
        wait_us(20);
        check_offers("t3");
        check("t3_req", byte_req, 1);
        check("t3_out", byte_out, 8'h16);
        check("t3_addr", byte_addr, 0);
        check("t3_count", byte_count, 0);
        check("t3_ovf", overflow, 1);
        ack_en = 1;
        wait_us(20);
        check("t3_count_ack", byte_count, 1);
        check("t3_addr_ack", byte_addr, 1);
        check("t3_ovf_sticky", overflow, 1);

        // Glitches inside data bits, a gap after 4 data bits, then a clean byte
        do_reset();
        d = 8'($urandom);
        send_frame(d, 4, 0, 0, 1);
        tape_in = 0;
        wait_us(1500);
        tape_in = 1;
        check_offers("t4_gap");
        check("t4_rec", recording, 1);
        d = 8'($urandom);
        send_frame(d, 8, 0, 1, 1);
        model_byte(d);
        wait_us(20);
        check_offers("t4");
        check("t4_addr", byte_addr, model_addr);

        // Motor off mid-byte, then 0xAA appended at the next address
        d = 8'($urandom);
        send_frame(d, 4, 0, 0, 0);
        motor_on = 0;
        wait_us(3);
        check("t5_rec_off", recording, 0);
        wait_us(1200);
        motor_on = 1;
        send_frame(8'hAA, 8, 0, 1, 0);
        model_byte(8'hAA);
        wait_us(20);
        check_offers("t5");
        check("t5_count", byte_count, exp_q.size());
        check("t5_ovf", overflow, 0);

        // Wrong parity bit, left unacknowledged, then reset mid-handshake
        ack_en = 0;
        send_frame(8'h01, 8, 1, 1, 0);
`ifdef ORIC_TAP_REC_PARITY_CHECK_EN
        wait_us(20);
        check("t6_perr", parity_err, 1);
`else
        model_byte(8'h01);
        wait_us(20);
`endif
        check_offers("t6");
        check("t6_req", byte_req, exp_q.size() % 2);
        check("t6_ovf", overflow, 0);
        do_reset();
        check("t6_rst_req", byte_req, 0);
        check("t6_rst_addr", byte_addr, 0);

        // Fill the address space, then one byte more
        ack_en = 1;
        for (int i = 0; i <= AMAX + 1; i++) begin
            d = 8'($urandom) | 8'hC3;
            send_frame(d, 8, 0, 1, 0);
            model_byte(d);
            wait_us(20);
            if (i == AMAX) begin
                check("t7_full", full, 1);
                check("t7_ovf_pre", overflow, 0);
            end
        end
        check_offers("t7");
        check("t7_addr_hold", byte_addr, AMAX);
        check("t7_ovf", overflow, model_ovf);
        check("t7_full_hold", full, model_full);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
